// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the multi-cycle serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;

  // Slice counter width; it never drops below one bit, even for a single slice.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake plus operand and result buses of the serial adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built from two half adders; chained BPC times per cycle.
module halfadder (
  output logic s,
  output logic c,
  input  logic a,
  input  logic b
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module full_adder (
  output logic s,
  output logic co,
  input  logic a,
  input  logic b,
  input  logic ci
);
  logic s0, c0, c1;

  halfadder u_ha0 (.s(s0), .c(c0), .a(a),  .b(b));
  halfadder u_ha1 (.s(s),  .c(c1), .a(s0), .b(ci));

  assign co = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: WIDTH-bit operands added LSB-first, BPC bits per clock,
// with start/busy/done handshake and atomically updated sum/cout/ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);
  localparam int N  = WIDTH / BPC;
  localparam int CW = cnt_w(N);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_RUN  = 2'(RUN);
  localparam logic [1:0] S_DONE = 2'(DONE);

  if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_cfg
    $error("serial_adder: BPC must divide WIDTH and WIDTH must be >= 2");
  end

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nxt;
  logic             carry;
  logic             busy_q, done_q, cout_q, ovf_q;
  logic [WIDTH-1:0] sum_q;
  logic [BPC:0]     c;
  logic [BPC-1:0]   s_sl;

  assign c[0] = carry;

  for (genvar i = 0; i < BPC; i++) begin : g_fa
    full_adder u_fa (
      .s (s_sl[i]),
      .co(c[i+1]),
      .a (a_sh[i]),
      .b (b_sh[i]),
      .ci(c[i])
    );
  end

  // New slice lands at the top; after N slices the LSB slice has reached bit 0.
  assign acc_nxt = (acc >> BPC) | (WIDTH'(s_sl) << (WIDTH - BPC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            carry  <= bus.cin;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= S_RUN;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh  <= a_sh >> BPC;
          b_sh  <= b_sh >> BPC;
          carry <= c[BPC];
          acc   <= acc_nxt;
          cnt   <= cnt + 1'b1;
          // Results are published only here so partial sums never leak out.
          if (cnt == CW'(N - 1)) begin
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            sum_q  <= acc_nxt;
            cout_q <= c[BPC];
            ovf_q  <= c[BPC] ^ c[BPC-1];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench: two adders (BPC=1 and BPC=2) checked against an arithmetic model.
module tb_serial_adder;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         s;
    int         t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   lat [2] = '{8, 4};
  exp_t q [2][$];
  exp_t hold [2];

  serial_adder_if #(.WIDTH(8)) if0 ();
  serial_adder_if #(.WIDTH(8)) if1 ();

  serial_adder #(.WIDTH(8), .BPC(1)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  serial_adder #(.WIDTH(8), .BPC(2)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  logic [1:0] busy_w, done_w, cout_w, ovf_w;
  logic [7:0] sum_w [2];
  assign busy_w   = {if1.busy, if0.busy};
  assign done_w   = {if1.done, if0.done};
  assign cout_w   = {if1.cout, if0.cout};
  assign ovf_w    = {if1.ovf,  if0.ovf};
  assign sum_w[0] = if0.sum;
  assign sum_w[1] = if1.sum;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", nm, d, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(logic [7:0] a, logic [7:0] b, logic ci);
    exp_t e;
    int   r;
    r      = int'(a) + int'(b) + int'(ci);
    e.sum  = 8'(r % 256);
    e.cout = (r >= 256);
    // Signed overflow: like-signed operands giving a result of the other sign.
    e.ovf  = (a[7] == b[7]) && (e.sum[7] != a[7]);
    e.s    = 0;
    e.t    = 0;
    return e;
  endfunction

  task automatic drive(int d, logic st, logic [7:0] a, logic [7:0] b, logic ci);
    if (d == 0) begin
      if0.start = st; if0.a = a; if0.b = b; if0.cin = ci;
    end else begin
      if1.start = st; if1.a = a; if1.b = b; if1.cin = ci;
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Waits for the adder to be free, presents one job and books its expected result.
  task automatic issue(int d, logic [7:0] a, logic [7:0] b, logic ci);
    exp_t e;
    int   w = 0;
    while (busy_w[d] !== 1'b0 && w < 50) begin
      step();
      w++;
    end
    if (w >= 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_timeout dut%0d: busy stuck at %0b, required 0", d, busy_w[d]);
      return;
    end
    e   = model(a, b, ci);
    e.s = cyc + 1;
    e.t = cyc + 1 + lat[d];
    q[d].push_back(e);
    drive(d, 1'b1, a, b, ci);
    step();
    drive(d, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic clear_expect();
    for (int d = 0; d < 2; d++) begin
      q[d].delete();
      hold[d] = model(8'h00, 8'h00, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit has, de, be;
      has = q[d].size() > 0;
      de  = has && (cyc == q[d][0].t);
      be  = has && (cyc >= q[d][0].s) && (cyc < q[d][0].t);
      chk("done", d, 32'(done_w[d]), 32'(de));
      chk("busy", d, 32'(busy_w[d]), 32'(be));
      if (has && cyc >= q[d][0].t) hold[d] = q[d].pop_front();
      chk("sum",  d, 32'(sum_w[d]),  32'(hold[d].sum));
      chk("cout", d, 32'(cout_w[d]), 32'(hold[d].cout));
      chk("ovf",  d, 32'(ovf_w[d]),  32'(hold[d].ovf));
    end
  end

  initial begin
    int w;
    clear_expect();
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0);

    // Asynchronous reset takes effect before any clock edge.
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", d, 32'(busy_w[d]), 32'd0);
      chk("rst_done", d, 32'(done_w[d]), 32'd0);
      chk("rst_sum",  d, 32'(sum_w[d]),  32'd0);
      chk("rst_cout", d, 32'(cout_w[d]), 32'd0);
      chk("rst_ovf",  d, 32'(ovf_w[d]),  32'd0);
    end
    step();
    step();
    rst = 1'b0;
    step();

    issue(0, 8'h5A, 8'h3C, 1'b0);
    issue(0, 8'hFF, 8'h01, 1'b0);
    issue(0, 8'h00, 8'h00, 1'b1);

    // Second job is presented in the DONE cycle of the first.
    issue(1, 8'h80, 8'h80, 1'b0);
    issue(1, 8'h01, 8'h02, 1'b0);

    // A start during RUN must be ignored along with its operands.
    issue(0, 8'h01, 8'h01, 1'b0);
    step();
    drive(0, 1'b1, 8'h11, 8'h22, 1'b1);
    step();
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Abort while slice 3 of 8 is pending.
    issue(0, 8'h33, 8'h44, 1'b0);
    repeat (3) step();
    rst = 1'b1;
    #1;
    clear_expect();
    for (int d = 0; d < 2; d++) begin
      chk("abort_busy", d, 32'(busy_w[d]), 32'd0);
      chk("abort_done", d, 32'(done_w[d]), 32'd0);
      chk("abort_sum",  d, 32'(sum_w[d]),  32'd0);
      chk("abort_cout", d, 32'(cout_w[d]), 32'd0);
    end
    step();
    rst = 1'b0;
    issue(0, 8'h0F, 8'h01, 1'b0);

    for (int i = 0; i < 40; i++) begin
      issue(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) step();
    end

    w = 0;
    while ((q[0].size() > 0 || q[1].size() > 0) && w < 100) begin
      step();
      w++;
    end
    if (w >= 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d/%0d results still outstanding, required 0/0", q[0].size(), q[1].size());
    end
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
